// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM state encoding, the MEM/WB
// payload bundle and the debug view of the controller.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // MEM/WB pipeline register contents, held in one register_arn instance.
  typedef struct packed {
    logic        valid;
    logic [15:0] mem_data;
    logic [15:0] alu_out;
    logic        reg_wr_en;
    logic [2:0]  wr_reg;
    logic [2:0]  wr_sel;
  } mem_wb_t;

  // Controller state made visible for checkers; wait_count is zero-extended.
  typedef struct packed {
    mem_state_e  state;
    logic [7:0]  wait_count;
    logic        err;
  } mem_stage_dbg_t;

endpackage

// File: rtl/mem_stage_register_arn.sv
// Generic N-bit register with asynchronous active-low reset and write enable.
module register_arn #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Clear on reset, otherwise capture d whenever en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one load/store per memory instruction to a multicycle
// data memory, stalls the upstream pipeline until the access completes and
// registers the MEM/WB payload, inserting a bubble on every stall cycle.
//
// Handshakes:
//  - Upstream: an instruction is presented while in_valid=1. It is consumed on
//    a rising edge where stall_req=0; while stall_req=1 upstream must hold all
//    in_* inputs stable.
//  - Memory: a request (mem_rd/mem_wr) is a single-cycle pulse, only issued on
//    a cycle with mem_busy=0. Completion is signalled by mem_done, on the
//    request cycle itself or any later cycle; mem_rdata is sampled with it.
import mem_stage_pkg::*;

module mem_stage #(
  parameter int TIMEOUT = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [15:0]    in_alu_out,
  input  logic [15:0]    in_wr_data,
  input  logic           in_mem_en,
  input  logic           in_mem_wr_en,
  input  logic           in_reg_wr_en,
  input  logic [2:0]     in_wr_reg,
  input  logic [2:0]     in_wr_sel,
  input  logic           mem_busy,
  input  logic           mem_done,
  input  logic [15:0]    mem_rdata,
  output logic [15:0]    mem_addr,
  output logic [15:0]    mem_wdata,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           stall_req,
  output logic           out_valid,
  output logic [15:0]    out_mem_data,
  output logic [15:0]    out_alu_out,
  output logic           out_reg_wr_en,
  output logic [2:0]     out_wr_reg,
  output logic [2:0]     out_wr_sel,
  output logic           err,
  output mem_stage_dbg_t dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [0:0]    state_q;
  mem_state_e    state;
  mem_state_e    state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          err_q;
  logic          set_err;
  logic          retire;
  logic          acc;
  logic          unaligned;
  mem_wb_t       wb_d;
  mem_wb_t       wb_q;

  assign acc       = in_valid & in_mem_en;
  assign unaligned = acc & in_alu_out[0];
  assign state     = mem_state_e'(state_q);

  assign mem_addr  = in_alu_out;
  assign mem_wdata = in_wr_data;

  // Next state, wait counter, request pulses, stall and retire decision.
  // Request pulses are suppressed while reset is asserted.
  always_comb begin
    state_next = state;
    count_next = count;
    stall_req  = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    retire     = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        count_next = '0;
        if (!acc) begin
          retire = 1'b1;
        end else if (unaligned) begin
          set_err = 1'b1;
        end else if (mem_busy) begin
          stall_req = 1'b1;
        end else begin
          mem_rd = ~in_mem_wr_en & rst_n;
          mem_wr = in_mem_wr_en & rst_n;
          if (mem_done) begin
            retire = 1'b1;
          end else begin
            stall_req  = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          retire     = 1'b1;
          state_next = ST_IDLE;
          count_next = '0;
        end else if (count == CW'(TIMEOUT - 1)) begin
          // Last allowed WAIT cycle without completion: abandon as a bubble.
          set_err    = 1'b1;
          state_next = ST_IDLE;
          count_next = '0;
        end else begin
          stall_req  = 1'b1;
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // MEM/WB payload: only a retiring instruction produces a live entry.
  always_comb begin
    wb_d.valid     = retire & in_valid;
    wb_d.mem_data  = (retire & acc & ~in_mem_wr_en) ? mem_rdata : 16'h0000;
    wb_d.alu_out   = in_alu_out;
    wb_d.reg_wr_en = retire & in_valid & in_reg_wr_en;
    wb_d.wr_reg    = in_wr_reg;
    wb_d.wr_sel    = in_wr_sel;
  end

  register_arn #(.N(1)) u_state (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (state_next),
    .q     (state_q)
  );

  register_arn #(.N(CW)) u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (count_next),
    .q     (count)
  );

  register_arn #(.N(1)) u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (set_err),
    .d     (1'b1),
    .q     (err_q)
  );

  register_arn #(.N($bits(mem_wb_t))) u_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (wb_d),
    .q     (wb_q)
  );

  assign out_valid     = wb_q.valid;
  assign out_mem_data  = wb_q.mem_data;
  assign out_alu_out   = wb_q.alu_out;
  assign out_reg_wr_en = wb_q.reg_wr_en;
  assign out_wr_reg    = wb_q.wr_reg;
  assign out_wr_sel    = wb_q.wr_sel;
  assign err           = err_q;

  assign dbg = '{state: state, wait_count: 8'(count), err: err_q};

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized instruction mix
// against a transaction-level model of stall length, request pulses, retired
// payload and the sticky error flag.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TIMEOUT = 31;
  localparam int EW      = 39;  // {alu_out, mem_data, reg_wr_en, wr_reg, wr_sel}

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [15:0]    in_alu_out;
  logic [15:0]    in_wr_data;
  logic           in_mem_en;
  logic           in_mem_wr_en;
  logic           in_reg_wr_en;
  logic [2:0]     in_wr_reg;
  logic [2:0]     in_wr_sel;
  logic           mem_busy;
  logic           mem_done;
  logic [15:0]    mem_rdata;
  logic [15:0]    mem_addr;
  logic [15:0]    mem_wdata;
  logic           mem_rd;
  logic           mem_wr;
  logic           stall_req;
  logic           out_valid;
  logic [15:0]    out_mem_data;
  logic [15:0]    out_alu_out;
  logic           out_reg_wr_en;
  logic [2:0]     out_wr_reg;
  logic [2:0]     out_wr_sel;
  logic           err;
  mem_stage_dbg_t dbg;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_alu_out    (in_alu_out),
    .in_wr_data    (in_wr_data),
    .in_mem_en     (in_mem_en),
    .in_mem_wr_en  (in_mem_wr_en),
    .in_reg_wr_en  (in_reg_wr_en),
    .in_wr_reg     (in_wr_reg),
    .in_wr_sel     (in_wr_sel),
    .mem_busy      (mem_busy),
    .mem_done      (mem_done),
    .mem_rdata     (mem_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .stall_req     (stall_req),
    .out_valid     (out_valid),
    .out_mem_data  (out_mem_data),
    .out_alu_out   (out_alu_out),
    .out_reg_wr_en (out_reg_wr_en),
    .out_wr_reg    (out_wr_reg),
    .out_wr_sel    (out_wr_sel),
    .err           (err),
    .dbg           (dbg)
  );

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic          err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every live MEM/WB entry must match the oldest expected retirement;
  // bubbles must never carry a register write.
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_alu_out",   32'(out_alu_out),   32'(e[38:23]));
        check("wb_mem_data",  32'(out_mem_data),  32'(e[22:7]));
        check("wb_reg_wr_en", 32'(out_reg_wr_en), 32'(e[6]));
        check("wb_wr_reg",    32'(out_wr_reg),    32'(e[5:3]));
        check("wb_wr_sel",    32'(out_wr_sel),    32'(e[2:0]));
      end
    end else begin
      check("bubble_reg_wr_en", 32'(out_reg_wr_en), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // One instruction, held until the stage stops stalling. The memory model
  // holds mem_busy for 'busy' cycles, then signals mem_done 'lat' cycles after
  // the request (0 = same cycle); lat > TIMEOUT means it never answers.
  task automatic run_instr(input logic valid, input logic mem_en, input logic wr,
                           input logic reg_wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [2:0] wreg,
                           input logic [2:0] wsel, input int busy, input int lat,
                           input logic [15:0] rdata);
    logic acc;
    logic unal;
    logic go;
    logic tmo;
    logic ended;
    logic exp_valid;
    int   exp_stall;
    int   stalls;
    int   pulses;
    int   pulse_k;
    int   bound;
    acc       = valid & mem_en;
    unal      = acc & addr[0];
    go        = acc & ~unal;
    tmo       = go & (lat > TIMEOUT);
    exp_stall = go ? busy + ((lat < TIMEOUT) ? lat : TIMEOUT) : 0;
    exp_valid = valid & ~unal & ~tmo;
    stalls    = 0;
    pulses    = 0;
    pulse_k   = -1;
    ended     = 1'b0;
    bound     = busy + TIMEOUT + 8;

    in_valid     = valid;
    in_mem_en    = mem_en;
    in_mem_wr_en = wr;
    in_reg_wr_en = reg_wr;
    in_alu_out   = addr;
    in_wr_data   = wdata;
    in_wr_reg    = wreg;
    in_wr_sel    = wsel;

    for (int k = 0; k < bound; k++) begin
      if (go) begin
        mem_busy = (k < busy);
        mem_done = (k >= busy) && ((k - busy) == lat);
      end else begin
        mem_busy = ($urandom_range(0, 1) == 1);
        mem_done = ($urandom_range(0, 1) == 1);
      end
      mem_rdata = mem_done ? rdata : 16'($urandom);
      @(negedge clk);
      if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
        pulses++;
        pulse_k = k;
        check("req_kind",  32'({mem_rd, mem_wr}), wr ? 32'd1 : 32'd2);
        check("req_addr",  32'(mem_addr),  32'(addr));
        check("req_wdata", 32'(mem_wdata), 32'(wdata));
      end
      if (stall_req !== 1'b1) begin
        ended = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end

    check("stall_ended",  32'(ended),  32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("req_pulses",   32'(pulses), go ? 32'd1 : 32'd0);
    if (go) check("req_cycle", 32'(pulse_k), 32'(busy));

    if (exp_valid)
      exp_q.push_back({addr, (go & ~wr & ~tmo) ? rdata : 16'h0000, reg_wr, wreg, wsel});
    if (unal | tmo) err_exp = 1'b1;

    if (ended) begin
      @(posedge clk);
      #1;
    end
    mem_busy = 1'b0;
    mem_done = 1'b0;
    check("err_flag", 32'(err), 32'(err_exp));
  endtask

  // Short reset pulse placed clear of both clock edges.
  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    err_exp = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Assert reset in the middle of a WAIT, then deliver a late mem_done.
  task automatic reset_mid_wait();
    in_valid     = 1'b1;
    in_mem_en    = 1'b1;
    in_mem_wr_en = 1'b0;
    in_reg_wr_en = 1'b1;
    in_alu_out   = 16'h0040;
    in_wr_reg    = 3'd6;
    in_wr_sel    = 3'd1;
    mem_busy     = 1'b0;
    mem_done     = 1'b0;
    @(negedge clk);
    check("rmw_req", 32'(mem_rd), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rmw_wait_no_req", 32'(mem_rd), 32'd0);
    check("rmw_wait_stall",  32'(stall_req), 32'd1);
    check("rmw_wait_state",  32'(dbg.state), 32'(ST_WAIT));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rmw_out_valid", 32'(out_valid),    32'd0);
    check("rmw_alu_out",   32'(out_alu_out),  32'd0);
    check("rmw_wr_reg",    32'(out_wr_reg),   32'd0);
    check("rmw_err",       32'(err),          32'd0);
    check("rmw_state",     32'(dbg.state),    32'(ST_IDLE));
    check("rmw_mem_rd",    32'(mem_rd),       32'd0);
    err_exp  = 1'b0;
    in_valid = 1'b0;
    mem_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("late_done_stall", 32'(stall_req), 32'd0);
    check("late_done_req",   32'({mem_rd, mem_wr}), 32'd0);
    @(posedge clk);
    #1;
    mem_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int         r;
    int         lat;
    int         busy;
    logic       valid;
    logic       mem_en;
    logic       wr;
    logic [15:0] addr;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_alu_out   = 16'h0;
    in_wr_data   = 16'h0;
    in_mem_en    = 1'b0;
    in_mem_wr_en = 1'b0;
    in_reg_wr_en = 1'b0;
    in_wr_reg    = 3'd0;
    in_wr_sel    = 3'd0;
    mem_busy     = 1'b0;
    mem_done     = 1'b0;
    mem_rdata    = 16'h0;

    #2;
    check("rst_out_valid",  32'(out_valid),     32'd0);
    check("rst_mem_data",   32'(out_mem_data),  32'd0);
    check("rst_alu_out",    32'(out_alu_out),   32'd0);
    check("rst_reg_wr_en",  32'(out_reg_wr_en), 32'd0);
    check("rst_wr_reg",     32'(out_wr_reg),    32'd0);
    check("rst_wr_sel",     32'(out_wr_sel),    32'd0);
    check("rst_err",        32'(err),           32'd0);
    check("rst_state",      32'(dbg.state),     32'(ST_IDLE));
    check("rst_wait_count", 32'(dbg.wait_count), 32'd0);
    check("rst_req",        32'({mem_rd, mem_wr}), 32'd0);
    check("rst_stall",      32'(stall_req),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU op, single-cycle pass-through
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 3'd3, 3'd0, 0, 0, 16'h0000);
    // load completing three cycles after the request
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 3'd5, 3'd1, 0, 3, 16'hBEEF);
    // store hit in the request cycle
    run_instr(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h5A5A, 3'd0, 3'd0, 0, 0, 16'h0000);
    // memory busy for two cycles before accepting a load
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000, 3'd2, 3'd1, 2, 1, 16'hCAFE);
    // load that completes on the last permitted WAIT cycle
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0032, 16'h0000, 3'd1, 3'd1, 0, TIMEOUT, 16'h7E57);
    // memory never answers: abandon, sticky err
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0000, 3'd4, 3'd1, 0, TIMEOUT + 5, 16'h1111);
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0000, 3'd7, 3'd2, 0, 0, 16'h0000);
    // reset in the middle of an access, then a normal load
    reset_mid_wait();
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0044, 16'h0000, 3'd6, 3'd1, 0, 2, 16'h4321);
    // unaligned load, then an ALU op retires normally
    run_instr(1'b1, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 3'd2, 3'd1, 0, 0, 16'hDEAD);
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000, 3'd1, 3'd0, 0, 0, 16'h0000);
    run_instr(1'b0, 1'b1, 1'b0, 1'b1, 16'h0060, 16'h0000, 3'd1, 3'd1, 0, 0, 16'h0000);

    do_reset();

    for (int i = 0; i < 150; i++) begin
      r      = int'($urandom_range(0, 9));
      valid  = ($urandom_range(0, 7) != 0);
      mem_en = (r < 6);
      wr     = (r < 3);
      addr   = 16'($urandom);
      if (mem_en && $urandom_range(0, 15) != 0) addr[0] = 1'b0;
      busy   = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3));
      r      = int'($urandom_range(0, 19));
      if (r < 8)       lat = 0;
      else if (r < 18) lat = int'($urandom_range(1, 5));
      else if (r == 18) lat = TIMEOUT;
      else             lat = TIMEOUT + 3;
      run_instr(valid, mem_en, wr, ($urandom_range(0, 1) == 1), addr, 16'($urandom),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), busy, lat,
                16'($urandom));
    end

    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit in case the DUT wedges the driver.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
    $fatal(1, "time limit");
  end

endmodule
